// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserialiser with a 2-flop input synchroniser, a mid-bit sampling FSM, and one-cycle dv/frame-error strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with an o_parity_err strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 391
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_serial,
    output logic       o_rx_active,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_parity_err
`endif
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY     = 3'd3,
`endif
        S_STOP       = 3'd4,
        S_CLEANUP    = 3'd5,
        S_BREAK_WAIT = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] clk_count_q, clk_count_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;
    logic             active_q, active_d;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit_q, parity_bit_d;
    logic             pe_q, pe_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            clk_count_q  <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            dv_q         <= 1'b0;
            fe_q         <= 1'b0;
            active_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            pe_q         <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= i_rx_serial;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            clk_count_q  <= clk_count_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            dv_q         <= dv_d;
            fe_q         <= fe_d;
            active_q     <= active_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            pe_q         <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        clk_count_d  = clk_count_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        dv_d         = 1'b0;
        fe_d         = 1'b0;
        active_d     = active_q;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        pe_d         = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                clk_count_d = '0;
                bit_idx_d   = '0;
                if (!rx_s_q) begin
                    state_d  = S_START;
                    active_d = 1'b1;
                end
            end
            S_START: begin
                // A start bit that is high again at its mid-point was a glitch.
                if (clk_count_q == HALF_LAST) begin
                    clk_count_d = '0;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    clk_count_d = clk_count_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d         = '0;
                    shift_d[bit_idx_q]  = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d  = '0;
                    parity_bit_d = rx_s_q;
                    state_d      = S_STOP;
                end else begin
                    clk_count_d = clk_count_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d = '0;
                    if (rx_s_q) begin
                        state_d = S_CLEANUP;
`ifdef UART_RX_PARITY_EN
                        if ((^shift_q) ^ parity_bit_q) begin
                            pe_d = 1'b1;
                        end else begin
                            byte_d = shift_q;
                            dv_d   = 1'b1;
                        end
`else
                        byte_d = shift_q;
                        dv_d   = 1'b1;
`endif
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK_WAIT;
                    end
                end else begin
                    clk_count_d = clk_count_q + CNT_W'(1);
                end
            end
            S_CLEANUP: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
            S_BREAK_WAIT: begin
                // A line held low (break) must go idle before a new start edge counts.
                active_d = 1'b0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                active_d    = 1'b0;
                clk_count_d = '0;
                bit_idx_d   = '0;
            end
        endcase
    end

    assign o_rx_active  = active_q;
    assign o_rx_dv      = dv_q;
    assign o_rx_byte    = byte_q;
    assign o_frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = pe_q;
`endif

endmodule
